imm_encoder: RTL

Iterative immediate encoder for the 32-bit CPU: the inverse of the immediate extender. It takes a 32-bit constant and an `ImmSrc` class and produces the 24-bit instruction immediate field. Feeding that field back through the extender with the same `ImmSrc` reproduces the constant. It sits beside the instruction-build and self-check logic and reports whether the constant is encodable at all. Data-processing constants are found by a per-cycle rotation search.

---
 rtl/imm_encoder_pkg.sv | 41 ++++
 rtl/imm_encoder_rot_check.sv | 19 +
 rtl/imm_encoder.sv | 104 ++++++++++
 3 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared immediate-class codes, FSM states and the direct (non-searched)
// encoding used by imm_encoder; the immediate extender uses the same codes.
package imm_encoder_pkg;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;
  localparam logic [1:0] IMM_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic        fit;
    logic [23:0] instr;
  } enc_res_t;

  // Load/store and branch classes encode in one step; anything else reports no fit.
  function automatic enc_res_t encodeDirect(input logic [31:0] value,
                                            input logic [1:0]  immSrc);
    enc_res_t res;
    res.fit   = 1'b0;
    res.instr = '0;
    case (immSrc)
      IMM_MEM: begin
        res.fit = (value[31:12] == 20'd0);
        if (res.fit) res.instr = {12'd0, value[11:0]};
      end
      IMM_BR: begin
        res.fit = (value[1:0] == 2'b00) && ((&value[31:25]) || !(|value[31:25]));
        if (res.fit) res.instr = value[25:2];
      end
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/imm_encoder_rot_check.sv
// Tests one data-processing rotation candidate: rotates Value left by 2k and
// reports whether the result fits in eight bits.
module imm_rot_check (
  input  logic [31:0] Value,
  input  logic [3:0]  k,
  output logic        hit,
  output logic [7:0]  imm8
);

  logic [4:0]  rotAmt;
  logic [31:0] rotated;

  // k=0 shifts right by 32, which yields zero and leaves Value unrotated.
  assign rotAmt  = {k, 1'b0};
  assign rotated = (Value << rotAmt) | (Value >> (6'd32 - {1'b0, rotAmt}));
  assign hit     = (rotated[31:8] == 24'd0);
  assign imm8    = rotated[7:0];

endmodule

// File: rtl/imm_encoder.sv
// Iterative immediate encoder: inverse of the immediate extender. Data-processing
// constants are found by a one-candidate-per-cycle rotation search.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ROT_STEPS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Value,
  input  logic [1:0]  ImmSrc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] Instr,
  output logic        fit
);

  localparam logic [3:0] LAST_K = 4'(ROT_STEPS - 1);

  state_e      state_q;
  logic [3:0]  k_q;
  logic [31:0] value_q;
  logic        inReady_q;
  logic        outValid_q;
  logic [23:0] instr_q;
  logic        fit_q;

  enc_res_t    direct_d;
  logic        rotHit_d;
  logic [7:0]  rotImm8_d;

  assign direct_d = encodeDirect(Value, ImmSrc);

  imm_rot_check u_rot_check (
    .Value (value_q),
    .k     (k_q),
    .hit   (rotHit_d),
    .imm8  (rotImm8_d)
  );

  // Smallest rotation wins because candidates are tested in ascending order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      value_q    <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      instr_q    <= '0;
      fit_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            value_q   <= Value;
            k_q       <= '0;
            inReady_q <= 1'b0;
            if (ImmSrc == IMM_DP) begin
              state_q <= ST_SEARCH;
            end else begin
              instr_q    <= direct_d.instr;
              fit_q      <= direct_d.fit;
              outValid_q <= 1'b1;
              state_q    <= ST_DONE;
            end
          end
        end
        ST_SEARCH: begin
          if (rotHit_d) begin
            instr_q    <= {12'd0, k_q, rotImm8_d};
            fit_q      <= 1'b1;
            outValid_q <= 1'b1;
            state_q    <= ST_DONE;
          end else if (k_q == LAST_K) begin
            instr_q    <= '0;
            fit_q      <= 1'b0;
            outValid_q <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign Instr     = instr_q;
  assign fit       = fit_q;

endmodule
